// File: rtl/dm_sba_host_pkg.sv
// Shared types for the debug-module system bus access engine:
// engine states, sberror codes and a helper that derives the widest
// legal access size from the host bus width.
package dm_sba_host_pkg;

    typedef enum logic [1:0] {
        SbaIdle    = 2'd0,
        SbaReqRd   = 2'd1,
        SbaReqWr   = 2'd2,
        SbaWaitRsp = 2'd3
    } sba_state_e;

    typedef enum logic [2:0] {
        SbErrNone    = 3'd0,
        SbErrTimeout = 3'd1,
        SbErrBus     = 3'd2,
        SbErrAlign   = 3'd3,
        SbErrSize    = 3'd4
    } sberr_e;

    // Largest sbaccess value (log2 of bytes) a bus of this width can carry.
    function automatic int unsigned sba_max_access(input int unsigned bus_width);
        return $clog2(bus_width / 8);
    endfunction

endpackage

// File: rtl/dm_sba_lane_align.sv
// Byte-lane alignment for system bus accesses: byte enables, lane-shifted
// write data, right-aligned/zero-extended read data, and the size and
// alignment legality check for an access at a given byte offset.
module dm_sba_lane_align
    import dm_sba_host_pkg::*;
#(
    parameter int unsigned BusWidth = 32
) (
    input  logic [$clog2(BusWidth/8)-1:0] off_i,
    input  logic [2:0]                    access_i,
    input  logic [BusWidth-1:0]           wdata_i,
    input  logic [BusWidth-1:0]           rdata_i,
    output logic [BusWidth/8-1:0]         be_o,
    output logic [BusWidth-1:0]           wdata_o,
    output logic [BusWidth-1:0]           rdata_o,
    output sberr_e                        err_o
);
    localparam int unsigned ByteW        = BusWidth / 8;
    localparam int unsigned OffW         = $clog2(ByteW);
    localparam int unsigned SbaMaxAccess = sba_max_access(BusWidth);

    logic [7:0]          nbytes;
    logic [15:0]         be_full;
    logic [OffW-1:0]     off_mask;
    logic [BusWidth-1:0] data_mask;

    // Lane shifting, size masking and legality check for one access.
    always_comb begin
        nbytes   = 8'd1 << access_i;
        be_full  = (16'd1 << nbytes) - 16'd1;
        off_mask = OffW'(nbytes - 8'd1);
        if (nbytes >= 8'(ByteW)) begin
            data_mask = '1;
        end else begin
            data_mask = (BusWidth'(1) << {nbytes, 3'b000}) - BusWidth'(1);
        end
        be_o    = ByteW'(be_full) << off_i;
        wdata_o = wdata_i << {off_i, 3'b000};
        rdata_o = (rdata_i >> {off_i, 3'b000}) & data_mask;
        // An oversized access is reported ahead of misalignment.
        if (access_i > 3'(SbaMaxAccess)) begin
            err_o = SbErrSize;
        end else if ((off_i & off_mask) != '0) begin
            err_o = SbErrAlign;
        end else begin
            err_o = SbErrNone;
        end
    end

endmodule

// File: rtl/dm_sba_host.sv
// System bus access host engine for the debug module: turns sbaddress/
// sbdata strobes into single host-bus transactions with lane alignment,
// autoincrement and error reporting.
// Optional feature: define DM_SBA_TIMEOUT_EN to abandon a transaction
// that sees no grant/response within TimeoutCycles cycles (error 1).
module dm_sba_host
    import dm_sba_host_pkg::*;
#(
    parameter int unsigned BusWidth      = 32,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   dmactive_i,
    input  logic [AddrWidth-1:0]   sbaddress_i,
    input  logic                   sbaddress_write_valid_i,
    output logic [AddrWidth-1:0]   sbaddress_o,
    input  logic                   sbreadonaddr_i,
    input  logic                   sbreadondata_i,
    input  logic                   sbautoincrement_i,
    input  logic [2:0]             sbaccess_i,
    input  logic [BusWidth-1:0]    sbdata_i,
    input  logic                   sbdata_write_valid_i,
    input  logic                   sbdata_read_valid_i,
    output logic [BusWidth-1:0]    sbdata_o,
    output logic                   sbdata_valid_o,
    output logic                   sbbusy_o,
    output logic                   sberror_valid_o,
    output logic [2:0]             sberror_o,
    output logic                   host_req_o,
    output logic                   host_we_o,
    output logic [AddrWidth-1:0]   host_add_o,
    output logic [BusWidth-1:0]    host_wdata_o,
    output logic [BusWidth/8-1:0]  host_be_o,
    input  logic                   host_gnt_i,
    input  logic                   host_r_valid_i,
    input  logic                   host_err_i,
    input  logic [BusWidth-1:0]    host_r_rdata_i
);
    localparam int unsigned ByteW = BusWidth / 8;
    localparam int unsigned OffW  = $clog2(ByteW);

    sba_state_e          state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AddrWidth-1:0] host_add_q, host_add_d;
    logic [BusWidth-1:0]  wdata_q, wdata_d;
    logic [ByteW-1:0]     be_q, be_d;
    logic                 we_q, we_d;
    logic [2:0]           access_q, access_d;
    logic [OffW-1:0]      off_q, off_d;
    logic [BusWidth-1:0]  sbdata_q, sbdata_d;
    logic                 sbdata_valid_q, sbdata_valid_d;
    logic                 err_valid_q, err_valid_d;
    sberr_e               err_q, err_d;

    logic [AddrWidth-1:0] addr_eff;
    logic                 trig_wr, trig_rd;
    logic [OffW-1:0]      align_off;
    logic [2:0]           align_access;
    logic [ByteW-1:0]     align_be;
    logic [BusWidth-1:0]  align_wdata, align_rdata;
    sberr_e               align_err;

`ifdef DM_SBA_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout;
    assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TimeoutCycles;
`endif

    // An address written this cycle is the one a read-on-address must use.
    assign addr_eff = sbaddress_write_valid_i ? sbaddress_i : addr_q;
    assign trig_wr  = sbdata_write_valid_i;
    assign trig_rd  = (sbaddress_write_valid_i && sbreadonaddr_i) ||
                      (sbdata_read_valid_i && sbreadondata_i);

    // Idle: evaluate the candidate access; busy: realign the pending read.
    assign align_off    = (state_q == SbaIdle) ? addr_eff[OffW-1:0] : off_q;
    assign align_access = (state_q == SbaIdle) ? sbaccess_i : access_q;

    dm_sba_lane_align #(
        .BusWidth (BusWidth)
    ) u_lane_align (
        .off_i    (align_off),
        .access_i (align_access),
        .wdata_i  (sbdata_i),
        .rdata_i  (host_r_rdata_i),
        .be_o     (align_be),
        .wdata_o  (align_wdata),
        .rdata_o  (align_rdata),
        .err_o    (align_err)
    );

    // Next-state, request latching, completion and abort handling.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_eff;
        host_add_d     = host_add_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        we_d           = we_q;
        access_d       = access_q;
        off_d          = off_q;
        sbdata_d       = sbdata_q;
        sbdata_valid_d = 1'b0;
        err_valid_d    = 1'b0;
        err_d          = SbErrNone;
`ifdef DM_SBA_TIMEOUT_EN
        cnt_d          = (state_q == SbaIdle) ? '0 : cnt_q + CntW'(1);
`endif
        unique case (state_q)
            SbaIdle: begin
                if (trig_wr || trig_rd) begin
                    if (align_err != SbErrNone) begin
                        err_valid_d = 1'b1;
                        err_d       = align_err;
                    end else begin
                        state_d    = trig_wr ? SbaReqWr : SbaReqRd;
                        host_add_d = {addr_eff[AddrWidth-1:OffW], {OffW{1'b0}}};
                        be_d       = align_be;
                        wdata_d    = trig_wr ? align_wdata : '0;
                        we_d       = trig_wr;
                        access_d   = sbaccess_i;
                        off_d      = addr_eff[OffW-1:0];
`ifdef DM_SBA_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end
                end
            end
            SbaReqRd, SbaReqWr: begin
                if (host_gnt_i) begin
                    state_d = SbaWaitRsp;
`ifdef DM_SBA_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d     = SbaIdle;
                    err_valid_d = 1'b1;
                    err_d       = SbErrTimeout;
`endif
                end
            end
            SbaWaitRsp: begin
                if (host_r_valid_i) begin
                    state_d = SbaIdle;
                    if (host_err_i) begin
                        err_valid_d = 1'b1;
                        err_d       = SbErrBus;
                    end else begin
                        if (!we_q) begin
                            sbdata_d       = align_rdata;
                            sbdata_valid_d = 1'b1;
                        end
                        // A debugger address write in the same cycle wins.
                        if (sbautoincrement_i && !sbaddress_write_valid_i) begin
                            addr_d = addr_q + (AddrWidth'(1) << access_q);
                        end
                    end
`ifdef DM_SBA_TIMEOUT_EN
                end else if (timeout) begin
                    state_d     = SbaIdle;
                    err_valid_d = 1'b1;
                    err_d       = SbErrTimeout;
`endif
                end
            end
            default: state_d = SbaIdle;
        endcase
        // Debug module deactivated: drop everything, including in-flight responses.
        if (!dmactive_i) begin
            state_d        = SbaIdle;
            addr_d         = '0;
            host_add_d     = '0;
            sbdata_valid_d = 1'b0;
            err_valid_d    = 1'b0;
            err_d          = SbErrNone;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= SbaIdle;
            addr_q         <= '0;
            host_add_q     <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            we_q           <= 1'b0;
            access_q       <= '0;
            off_q          <= '0;
            sbdata_q       <= '0;
            sbdata_valid_q <= 1'b0;
            err_valid_q    <= 1'b0;
            err_q          <= SbErrNone;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            host_add_q     <= host_add_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            we_q           <= we_d;
            access_q       <= access_d;
            off_q          <= off_d;
            sbdata_q       <= sbdata_d;
            sbdata_valid_q <= sbdata_valid_d;
            err_valid_q    <= err_valid_d;
            err_q          <= err_d;
        end
    end

`ifdef DM_SBA_TIMEOUT_EN
    // Cycles spent waiting in the current request/response phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign sbaddress_o     = addr_q;
    assign sbdata_o        = sbdata_q;
    assign sbdata_valid_o  = sbdata_valid_q;
    assign sbbusy_o        = (state_q != SbaIdle);
    assign sberror_valid_o = err_valid_q;
    assign sberror_o       = err_q;
    assign host_req_o      = (state_q == SbaReqRd) || (state_q == SbaReqWr);
    assign host_we_o       = (state_q == SbaReqWr);
    assign host_add_o      = host_add_q;
    assign host_wdata_o    = wdata_q;
    assign host_be_o       = be_q;

endmodule

// File: tb/tb_dm_sba_host.sv
// Directed bench for dm_sba_host (32-bit bus, short timeout for the
// optional DM_SBA_TIMEOUT_EN build).
module tb_dm_sba_host;
    localparam int unsigned BW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dmactive;
    logic [AW-1:0] sbaddress_i;
    logic          sbaddress_wv;
    logic [AW-1:0] sbaddress_o;
    logic          readonaddr, readondata, autoinc;
    logic [2:0]    sbaccess;
    logic [BW-1:0] sbdata_i;
    logic          sbdata_wv, sbdata_rv;
    logic [BW-1:0] sbdata_o;
    logic          sbdata_valid, sbbusy, sberr_valid;
    logic [2:0]    sberr;
    logic          host_req, host_we;
    logic [AW-1:0] host_add;
    logic [BW-1:0] host_wdata;
    logic [BW/8-1:0] host_be;
    logic          host_gnt, host_r_valid, host_err;
    logic [BW-1:0] host_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dm_sba_host #(.BusWidth(BW), .AddrWidth(AW), .TimeoutCycles(TO)) dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .dmactive_i              (dmactive),
        .sbaddress_i             (sbaddress_i),
        .sbaddress_write_valid_i (sbaddress_wv),
        .sbaddress_o             (sbaddress_o),
        .sbreadonaddr_i          (readonaddr),
        .sbreadondata_i          (readondata),
        .sbautoincrement_i       (autoinc),
        .sbaccess_i              (sbaccess),
        .sbdata_i                (sbdata_i),
        .sbdata_write_valid_i    (sbdata_wv),
        .sbdata_read_valid_i     (sbdata_rv),
        .sbdata_o                (sbdata_o),
        .sbdata_valid_o          (sbdata_valid),
        .sbbusy_o                (sbbusy),
        .sberror_valid_o         (sberr_valid),
        .sberror_o               (sberr),
        .host_req_o              (host_req),
        .host_we_o               (host_we),
        .host_add_o              (host_add),
        .host_wdata_o            (host_wdata),
        .host_be_o               (host_be),
        .host_gnt_i              (host_gnt),
        .host_r_valid_i          (host_r_valid),
        .host_err_i              (host_err),
        .host_r_rdata_i          (host_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load sbaddress for one cycle, optionally triggering a read.
    task automatic set_addr(input logic [AW-1:0] a, input logic rd);
        sbaddress_i  = a;
        sbaddress_wv = 1'b1;
        readonaddr   = rd;
        tick();
        sbaddress_wv = 1'b0;
        readonaddr   = 1'b0;
    endtask

    // Act as the bus target: grant the pending request, then respond.
    task automatic serve(input logic [BW-1:0] rdata, input logic err);
        int n;
        n = 0;
        while (!host_req && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", host_req, 1);
        host_gnt = 1'b1;
        tick();
        host_gnt = 1'b0;
        check("req_drop_after_gnt", host_req, 0);
        host_r_valid = 1'b1;
        host_rdata   = rdata;
        host_err     = err;
        tick();
        host_r_valid = 1'b0;
        host_err     = 1'b0;
        host_rdata   = '0;
    endtask

    initial begin
        logic [AW-1:0] exp_addr;
        int n;
        rst_n = 1'b0; dmactive = 1'b1;
        sbaddress_i = '0; sbaddress_wv = 0; readonaddr = 0; readondata = 0; autoinc = 0;
        sbaccess = '0; sbdata_i = '0; sbdata_wv = 0; sbdata_rv = 0;
        host_gnt = 0; host_r_valid = 0; host_err = 0; host_rdata = '0;
        tick();
        check("rst_req", host_req, 0);
        check("rst_busy", sbbusy, 0);
        check("rst_addr", sbaddress_o, 0);
        check("rst_errv", sberr_valid, 0);
        check("rst_be", host_be, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: halfword write at byte offset 2
        set_addr(32'h1000_0002, 1'b0);
        check("t1_addr", sbaddress_o, 32'h1000_0002);
        check("t1_busy_idle", sbbusy, 0);
        sbaccess = 3'd1; sbdata_i = 32'h0000_BEEF; sbdata_wv = 1'b1;
        tick();
        sbdata_wv = 1'b0;
        check("t1_req", host_req, 1);
        check("t1_we", host_we, 1);
        check("t1_add", host_add, 32'h1000_0000);
        check("t1_be", host_be, 4'b1100);
        check("t1_wdata", host_wdata, 32'hBEEF_0000);
        tick();
        check("t1_req_hold", host_req, 1);
        check("t1_add_hold", host_add, 32'h1000_0000);
        serve('0, 1'b0);
        check("t1_done_busy", sbbusy, 0);
        check("t1_no_dvalid", sbdata_valid, 0);
        check("t1_no_err", sberr_valid, 0);

        // 2: byte read at offset 3
        sbaccess = 3'd0;
        set_addr(32'h0000_0003, 1'b1);
        check("t2_req", host_req, 1);
        check("t2_we", host_we, 0);
        check("t2_add", host_add, 32'h0);
        check("t2_be", host_be, 4'b1000);
        serve(32'hAB00_0000, 1'b0);
        check("t2_dvalid", sbdata_valid, 1);
        check("t2_data", sbdata_o, 32'h0000_00AB);
        tick();
        check("t2_dvalid_pulse", sbdata_valid, 0);

        // 3: autoincrementing word reads wrapping past the top of memory
        sbaccess = 3'd2; autoinc = 1'b1; readondata = 1'b1;
        set_addr(32'hFFFF_FFF8, 1'b0);
        exp_addr = 32'hFFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            sbdata_rv = 1'b1;
            tick();
            sbdata_rv = 1'b0;
            check("t3_add", host_add, exp_addr);
            check("t3_be", host_be, 4'b1111);
            serve(32'h1111_0000 + i, 1'b0);
            check("t3_data", sbdata_o, 32'h1111_0000 + i);
            exp_addr = exp_addr + 32'd4;
            check("t3_next_addr", sbaddress_o, exp_addr);
        end
        readondata = 1'b0;

        // 4: misaligned word write, then oversized access
        autoinc = 1'b0;
        set_addr(32'h0000_0002, 1'b0);
        sbaccess = 3'd2; sbdata_wv = 1'b1;
        tick();
        sbdata_wv = 1'b0;
        check("t4_align_errv", sberr_valid, 1);
        check("t4_align_code", sberr, 3);
        check("t4_align_req", host_req, 0);
        tick();
        check("t4_align_req2", host_req, 0);
        check("t4_errv_pulse", sberr_valid, 0);
        set_addr(32'h0000_0000, 1'b0);
        sbaccess = 3'd3; sbdata_wv = 1'b1;
        tick();
        sbdata_wv = 1'b0;
        check("t4_size_errv", sberr_valid, 1);
        check("t4_size_code", sberr, 4);
        check("t4_size_busy", sbbusy, 0);

        // write wins over a simultaneous read trigger
        sbaccess = 3'd2; sbdata_i = 32'h1234_5678;
        sbaddress_i = 32'h0000_0040; sbaddress_wv = 1'b1; readonaddr = 1'b1; sbdata_wv = 1'b1;
        tick();
        sbaddress_wv = 0; readonaddr = 0; sbdata_wv = 0;
        check("prio_we", host_we, 1);
        check("prio_add", host_add, 32'h40);
        check("prio_wdata", host_wdata, 32'h1234_5678);
        serve('0, 1'b0);

        // 5: bus error response, no autoincrement
        autoinc = 1'b1;
        set_addr(32'h0000_0100, 1'b1);
        serve(32'hDEAD_BEEF, 1'b1);
        check("t5_errv", sberr_valid, 1);
        check("t5_code", sberr, 2);
        check("t5_addr", sbaddress_o, 32'h100);
        check("t5_busy", sbbusy, 0);
        check("t5_no_dvalid", sbdata_valid, 0);
        check("t5_data_kept", sbdata_o, 32'h1111_0003);
        autoinc = 1'b0;

        // 6: grant withheld
        set_addr(32'h0000_0200, 1'b1);
        n = 0;
        while (host_req && n < 40) begin
            n++;
            tick();
        end
`ifdef DM_SBA_TIMEOUT_EN
        check("t6_to_cycles", n, TO);
        check("t6_to_errv", sberr_valid, 1);
        check("t6_to_code", sberr, 1);
        check("t6_to_busy", sbbusy, 0);
        set_addr(32'h0000_0200, 1'b1);
        tick();
        tick();
`else
        check("t6_wait_forever", n, 40);
        check("t6_no_err", sberr_valid, 0);
`endif
        check("t6_req_before_abort", host_req, 1);
        dmactive = 1'b0;
        tick();
        check("t6_abort_req", host_req, 0);
        check("t6_abort_busy", sbbusy, 0);
        check("t6_abort_addr", sbaddress_o, 0);
        dmactive = 1'b1;
        // stray response while idle must be ignored
        host_r_valid = 1'b1; host_rdata = 32'h5555_5555;
        tick();
        host_r_valid = 1'b0;
        tick();
        check("t6_stray_dvalid", sbdata_valid, 0);
        check("t6_stray_busy", sbbusy, 0);
        check("t6_stray_data", sbdata_o, 32'h1111_0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
